// File: rtl/lockstep_pkg.sv
// Shared state type and constants for the lockstep counter checker.
package lockstep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lockstep_state_t;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/lockstep_chan_cmp.sv
// One observed channel compared against the reference counter; a lag-1 channel
// follows the previous reference value and has nothing to compare in cycle 0.
module lockstep_chan_cmp
    import lockstep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] obs,
    input  logic [WIDTH-1:0] ref_count,
    input  logic [WIDTH-1:0] ref_prev,
    input  logic             lag,
    input  logic             first_cycle,
    output logic             mismatch
);

    assign mismatch = lag ? (!first_cycle && (obs != ref_prev))
                          : (obs != ref_count);

endmodule

// File: rtl/lockstep_count_checker.sv
// Runs a reference counter for NUM_TESTS cycles and checks every channel against
// it, keeping sticky per-channel flags, a first-error record and an error count.
module lockstep_count_checker
    import lockstep_pkg::*;
#(
    parameter  int NUM_CHANNELS = 2,
    parameter  int WIDTH        = 8,
    parameter  int NUM_TESTS    = 100,
    parameter  int STOP_ON_ERR  = 0,
    localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int CYC_W        = $clog2(NUM_TESTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CHANNELS*WIDTH-1:0] chan_count,
    input  logic [NUM_CHANNELS-1:0]       chan_lag,
    output logic [WIDTH-1:0]              ref_count,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [NUM_CHANNELS-1:0]       err_mask,
    output logic [CHAN_W-1:0]             first_err_chan,
    output logic [CYC_W-1:0]              first_err_cycle,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(NUM_TESTS - 1);

    lockstep_state_t             state_q, state_d;
    logic [WIDTH-1:0]            ref_q, ref_d;
    logic [WIDTH-1:0]            prev_q, prev_d;
    logic [CYC_W-1:0]            cyc_q, cyc_d;
    logic [NUM_CHANNELS-1:0]     mask_q, mask_d;
    logic [CHAN_W-1:0]           fchan_q, fchan_d;
    logic [CYC_W-1:0]            fcyc_q, fcyc_d;
    logic [ERR_CNT_W-1:0]        ecnt_q, ecnt_d;
    logic                        pass_q, pass_d;

    logic [NUM_CHANNELS-1:0]     mism;
    logic [CHAN_W-1:0]           fail_chan;
    logic                        any_mism;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        lockstep_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
            .obs         (chan_count[i*WIDTH +: WIDTH]),
            .ref_count   (ref_q),
            .ref_prev    (prev_q),
            .lag         (chan_lag[i]),
            .first_cycle (cyc_q == '0),
            .mismatch    (mism[i])
        );
    end

    assign any_mism = |mism;

    // Descending scan so the lowest failing index is the one left standing.
    always_comb begin
        fail_chan = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mism[i]) fail_chan = CHAN_W'(i);
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        ref_d   = ref_q;
        prev_d  = prev_q;
        cyc_d   = cyc_q;
        mask_d  = mask_q;
        fchan_d = fchan_q;
        fcyc_d  = fcyc_q;
        ecnt_d  = ecnt_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    ref_d   = '0;
                    prev_d  = '0;
                    cyc_d   = '0;
                    mask_d  = '0;
                    fchan_d = '0;
                    fcyc_d  = '0;
                    ecnt_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (any_mism) begin
                    mask_d = mask_q | mism;
                    if (ecnt_q != '1) ecnt_d = ecnt_q + ERR_CNT_W'(1);
                    // A zero count means no earlier failing cycle in this run.
                    if (ecnt_q == '0) begin
                        fchan_d = fail_chan;
                        fcyc_d  = cyc_q;
                    end
                end
                if ((cyc_q == LAST_CYC) || ((STOP_ON_ERR != 0) && any_mism)) begin
                    state_d = DONE;
                    pass_d  = (mask_d == '0);
                end else begin
                    prev_d = ref_q;
                    ref_d  = ref_q + WIDTH'(1);
                    cyc_d  = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            prev_q  <= '0;
            cyc_q   <= '0;
            mask_q  <= '0;
            fchan_q <= '0;
            fcyc_q  <= '0;
            ecnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            prev_q  <= prev_d;
            cyc_q   <= cyc_d;
            mask_q  <= mask_d;
            fchan_q <= fchan_d;
            fcyc_q  <= fcyc_d;
            ecnt_q  <= ecnt_d;
            pass_q  <= pass_d;
        end
    end

    assign ref_count       = ref_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_mask        = mask_q;
    assign first_err_chan  = fchan_q;
    assign first_err_cycle = fcyc_q;
    assign err_count       = ecnt_q;

endmodule

// File: doc/lockstep_count_checker.md
# lockstep_count_checker

Race-free, parametrised self-checking counter monitor for simulation benches and on-chip test. A single registered reference counter runs for a fixed number of cycles, and `NUM_CHANNELS` observed counters are compared against it. Each channel can be declared zero-lag or one-cycle-lag, so producer/consumer sampling-order differences become an explicit, checked property rather than a scheduling accident. Errors are captured as sticky per-channel flags, a first-error record and a saturating count.

## Interface
- `NUM_CHANNELS`, 2, number of observed counters (≥1)
- `WIDTH`, 8, counter width in bits (≥1)
- `NUM_TESTS`, 100, compare cycles per run (≥1)
- `STOP_ON_ERR`, 0, 1 = terminate the run on the first mismatch
- `clk`  in  1  single clock; all state on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `chan_count`  in  NUM_CHANNELS*WIDTH  observed counters; channel i at bits [i*WIDTH +: WIDTH]
- `chan_lag`  in  NUM_CHANNELS  per-channel lag; 0 = channel equals reference in the same cycle, 1 = channel equals reference of the previous cycle
- `ref_count`  out  WIDTH  reference counter
- `busy`  out  1  run in progress
- `done`  out  1  run finished; held until restart or reset
- `pass`  out  1  valid when `done`; 1 iff no mismatch occurred
- `err_mask`  out  NUM_CHANNELS  sticky per-channel mismatch flags
- `first_err_chan`  out  max(1,$clog2(NUM_CHANNELS))  lowest-index channel failing in the first failing cycle
- `first_err_cycle`  out  $clog2(NUM_TESTS+1)  run cycle index n of the first mismatch
- `err_count`  out  16  number of cycles with ≥1 mismatch; saturates at 16'hFFFF

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`. DONE -> RUN on `start`. RUN -> DONE after cycle n = NUM_TESTS-1, or, with STOP_ON_ERR=1, after the first cycle containing a mismatch.
- `start` in RUN is ignored.
- Entering RUN clears `ref_count`, the cycle index, `err_mask`, `first_err_*`, `err_count` and `pass`.
- RUN cycle n (n = 0..NUM_TESTS-1): `ref_count` = n mod 2^WIDTH; `ref_prev` holds the previous cycle's `ref_count`.
- Expected value for channel i: `ref_count` if `chan_lag[i]`=0, otherwise `ref_prev`.
- Lag-1 channels are not compared in cycle n=0.
- A cycle with any mismatch increments `err_count` (saturating) and ORs the failing channels into `err_mask`.
- On the first failing cycle of a run, `first_err_chan` and `first_err_cycle` are latched. They are never overwritten later in that run.
- All arithmetic is modulo 2^WIDTH, so wrap-around (2^WIDTH-1 -> 0) is legal and is compared as wrapped values.
- `pass` is set on entry to DONE as (`err_mask`==0). It is 0 while RUN or IDLE.
- `rst` in any state returns to IDLE within the cycle. It also aborts any run in progress.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- If `start` is sampled at edge e, then `busy`=1 and `ref_count`=0 (cycle n=0) from e until e+NUM_TESTS.
- `done`=1 and `busy`=0 after edge e+NUM_TESTS.
- `chan_count` for cycle n is sampled at the edge ending cycle n. The error outputs reflect it after that same edge, which is one cycle of registered latency.
- STOP_ON_ERR=1 with a mismatch in cycle n: `done`=1 and `pass`=0 are visible in cycle n+1, and `ref_count` freezes.
- `start` in the same cycle as `rst`: `rst` wins.
- `chan_lag` is sampled every cycle and must stay stable during a run; if it changes mid-run, the result is the compare applied with the new value.

## Structure
- Package `lockstep_pkg` holds:
  - the state enum typedef `lockstep_state_t`;
  - the constant `ERR_CNT_W = 16`.
- Sub-module `lockstep_chan_cmp`, instantiated once per channel in a generate loop.
  - Inputs: observed value, `ref_count`, `ref_prev`, lag, and the first-cycle qualifier.
  - Output: a one-bit mismatch.
- Top level holds the FSM, the counters, the first-error priority encoder (lowest index) and the saturating error counter.

## Test plan
- Default parameters, both channels lag 0, driven from `ref_count` -> `done` 100 cycles after `start`, `pass`=1, `err_mask`=2'b00, `err_count`=0.
- Channel 1 driven from `ref_count` delayed by one register (reset 0):
  - with `chan_lag[1]`=1 -> `pass`=1;
  - with `chan_lag[1]`=0 -> `err_mask`=2'b10, `err_count`=99, `first_err_chan`=1, `first_err_cycle`=1.
- Both channels corrupted in n=37 only -> `err_mask`=2'b11, `err_count`=1, `first_err_chan`=0, `first_err_cycle`=37, `pass`=0.
- STOP_ON_ERR=1, channel 0 corrupted at n=10 -> `done`=1 in cycle 11, `busy`=0, `first_err_cycle`=10, `ref_count` holds 10.
- WIDTH=4, NUM_TESTS=40, lag-0 channel driven from `ref_count` -> `ref_count` wraps 15->0 twice, `pass`=1; a restart via `start` in DONE clears all error outputs.
- `rst` at n=50 -> next cycle all outputs are 0 and the state is IDLE; a following `start` gives a complete 100-cycle run with `pass`=1.
